// File: rtl/serv_seq_if.sv
// Handshake and control bundle between the bit-serial sequencer and the rest of the core.
// master is the sequencer's view; slave is the surrounding datapath/bus view.
interface serv_seq_if;
  logic       i_ibus_ack;
  logic       o_ibus_cyc;
  logic       i_dbus_ack;
  logic       o_dbus_cyc;
  logic       i_rf_ready;
  logic       o_rf_rreq;
  logic       o_rf_wreq;
  logic       i_two_stage_op;
  logic       i_branch_op;
  logic       i_cond_branch;
  logic       i_bne_or_bge;
  logic       i_dbus_en;
  logic       i_mdu_op;
  logic       i_e_op;
  logic       i_alu_cmp;
  logic       i_ctrl_misalign;
  logic       i_mem_misalign;
  logic       i_new_irq;
  logic       i_mdu_ready;
  logic [4:0] o_cnt;
  logic       o_cnt_en;
  logic       o_cnt_done;
  logic       o_init;
  logic       o_ctrl_pc_en;
  logic       o_ctrl_jump;
  logic       o_ctrl_trap;
  logic [1:0] o_mem_bytecnt;
  logic       o_mdu_valid;

  modport master (
    input  i_ibus_ack, i_dbus_ack, i_rf_ready, i_two_stage_op, i_branch_op,
           i_cond_branch, i_bne_or_bge, i_dbus_en, i_mdu_op, i_e_op, i_alu_cmp,
           i_ctrl_misalign, i_mem_misalign, i_new_irq, i_mdu_ready,
    output o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_cnt, o_cnt_en,
           o_cnt_done, o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap,
           o_mem_bytecnt, o_mdu_valid
  );

  modport slave (
    output i_ibus_ack, i_dbus_ack, i_rf_ready, i_two_stage_op, i_branch_op,
           i_cond_branch, i_bne_or_bge, i_dbus_en, i_mdu_op, i_e_op, i_alu_cmp,
           i_ctrl_misalign, i_mem_misalign, i_new_irq, i_mdu_ready,
    input  o_ibus_cyc, o_dbus_cyc, o_rf_rreq, o_rf_wreq, o_cnt, o_cnt_en,
           o_cnt_done, o_init, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap,
           o_mem_bytecnt, o_mdu_valid
  );
endinterface

// File: rtl/serv_seq.sv
// Instruction sequencer for a bit-serial RISC-V core: fetch, RF handshake,
// two-phase execution (INIT/RUN) with memory, MDU and trap detours.
module serv_seq #(
  parameter int unsigned W        = 1,
  parameter int unsigned WITH_CSR = 1,
  parameter int unsigned ALIGN    = 0,
  parameter int unsigned MDU      = 0
) (
  input logic       i_clk,
  input logic       i_rst_n,
  serv_seq_if.master bus
);

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
      $error("serv_seq: W must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] RFWAIT  = 3'd1;
  localparam logic [2:0] INIT    = 3'd2;
  localparam logic [2:0] MEMWAIT = 3'd3;
  localparam logic [2:0] MDUWAIT = 3'd4;
  localparam logic [2:0] RUN     = 3'd5;

  localparam logic [4:0] CNT_STEP = 5'(W);
  localparam logic [4:0] CNT_LAST = 5'(32 - W);
  localparam logic       CSR_EN   = (WITH_CSR != 0);
  localparam logic       ALIGN_EN = (ALIGN != 0);
  localparam logic       MDU_EN   = (MDU != 0);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] cnt;
  logic       ibus_cyc;
  logic       jump;
  logic       trap_flag;
  logic       init_done;

  logic cnt_en;
  logic cnt_done;
  logic last_init;
  logic run_done;
  logic fetch_ack;
  logic mem_done;
  logic mdu_done;
  logic mdu_req;
  logic take_branch;
  logic trap_pending;

  assign cnt_en    = (state == INIT) || (state == RUN);
  assign cnt_done  = cnt_en && (cnt == CNT_LAST);
  assign last_init = (state == INIT) && cnt_done;
  assign run_done  = (state == RUN) && cnt_done;
  assign fetch_ack = (state == FETCH) && ibus_cyc && bus.i_ibus_ack;
  assign mem_done  = (state == MEMWAIT) && bus.i_dbus_ack;
  assign mdu_done  = MDU_EN && (state == MDUWAIT) && bus.i_mdu_ready;
  assign mdu_req   = MDU_EN && bus.i_mdu_op;

  assign take_branch  = bus.i_branch_op &&
                        (!bus.i_cond_branch || (bus.i_alu_cmp ^ bus.i_bne_or_bge));
  assign trap_pending = CSR_EN &&
                        ((take_branch && bus.i_ctrl_misalign && !ALIGN_EN) ||
                         (bus.i_dbus_en && bus.i_mem_misalign));

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (fetch_ack) state_nxt = RFWAIT;
      RFWAIT:  if (bus.i_rf_ready)
                 state_nxt = (bus.i_two_stage_op && !bus.i_new_irq && !init_done) ? INIT : RUN;
      INIT:    if (cnt_done) begin
                 if (trap_pending)       state_nxt = RFWAIT;
                 else if (bus.i_dbus_en) state_nxt = MEMWAIT;
                 else if (mdu_req)       state_nxt = MDUWAIT;
                 else                    state_nxt = RFWAIT;
               end
      MEMWAIT: if (mem_done) state_nxt = RFWAIT;
      MDUWAIT: if (mdu_done) state_nxt = RFWAIT;
      RUN:     if (cnt_done) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= FETCH;
      cnt       <= '0;
      ibus_cyc  <= 1'b0;
      jump      <= 1'b0;
      trap_flag <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_en ? cnt + CNT_STEP : '0;
      // Registered from next state so the request rises one edge after reset release.
      ibus_cyc <= (state_nxt == FETCH);
      if (last_init) begin
        jump      <= take_branch;
        init_done <= 1'b1;
        if (trap_pending) trap_flag <= 1'b1;
      end
      if (run_done) begin
        jump      <= 1'b0;
        init_done <= 1'b0;
        trap_flag <= 1'b0;
      end
    end
  end

  assign bus.o_ibus_cyc    = ibus_cyc;
  assign bus.o_dbus_cyc    = (state == MEMWAIT);
  assign bus.o_mdu_valid   = MDU_EN && (state == MDUWAIT);
  assign bus.o_rf_rreq     = fetch_ack || (last_init && trap_pending);
  assign bus.o_rf_wreq     = (last_init && !trap_pending && !bus.i_dbus_en && !mdu_req) ||
                             mem_done || mdu_done;
  assign bus.o_cnt         = cnt;
  assign bus.o_cnt_en      = cnt_en;
  assign bus.o_cnt_done    = cnt_done;
  assign bus.o_init        = (state == INIT);
  assign bus.o_ctrl_pc_en  = cnt_en && (state != INIT);
  assign bus.o_ctrl_jump   = jump;
  assign bus.o_ctrl_trap   = CSR_EN && (bus.i_e_op || bus.i_new_irq || trap_flag);
  assign bus.o_mem_bytecnt = cnt[4:3];

endmodule

// File: tb/tb_serv_seq.sv
// Directed self-checking bench for serv_seq across three parameterisations.
module tb_serv_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serv_seq_if b1 ();
  serv_seq_if b4 ();
  serv_seq_if b8 ();

  serv_seq #(.W(1)) u_w1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1.master));
  serv_seq #(.W(4), .WITH_CSR(1), .ALIGN(0), .MDU(0)) u_w4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4.master));
  serv_seq #(.W(8), .WITH_CSR(1), .ALIGN(1), .MDU(1)) u_w8 (.i_clk(clk), .i_rst_n(rst_n), .bus(b8.master));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in(input virtual serv_seq_if v);
    v.i_ibus_ack = 0; v.i_dbus_ack = 0; v.i_rf_ready = 0; v.i_two_stage_op = 0;
    v.i_branch_op = 0; v.i_cond_branch = 0; v.i_bne_or_bge = 0; v.i_dbus_en = 0;
    v.i_mdu_op = 0; v.i_e_op = 0; v.i_alu_cmp = 0; v.i_ctrl_misalign = 0;
    v.i_mem_misalign = 0; v.i_new_irq = 0; v.i_mdu_ready = 0;
  endtask

  task automatic chk_reset(input virtual serv_seq_if v, input string tag);
    check(tag, {v.o_ibus_cyc, v.o_cnt_en, v.o_cnt, v.o_cnt_done, v.o_rf_rreq, v.o_rf_wreq,
                v.o_ctrl_jump, v.o_ctrl_trap, v.o_init, v.o_ctrl_pc_en, v.o_dbus_cyc,
                v.o_mdu_valid, v.o_mem_bytecnt}, 32'd0);
  endtask

  // Entered at posedge+3 in FETCH with ibus_cyc high; leaves at posedge+3 in INIT or RUN.
  task automatic do_fetch(input virtual serv_seq_if v, input string tag);
    v.i_ibus_ack = 1; #1;
    check({tag, "_fetch"}, {v.o_ibus_cyc, v.o_rf_rreq, v.o_rf_wreq}, 3'b110);
    tick(); v.i_ibus_ack = 0; v.i_rf_ready = 1; #1;
    check({tag, "_rfwait"}, {v.o_ibus_cyc, v.o_rf_rreq, v.o_cnt_en, v.o_init}, 4'b0000);
    tick(); v.i_rf_ready = 0; #1;
  endtask

  task automatic do_rfwait(input virtual serv_seq_if v, input string tag);
    v.i_rf_ready = 1; #1;
    check({tag, "_rfw2"}, {v.o_cnt_en, v.o_rf_rreq, v.o_rf_wreq}, 3'b000);
    tick(); v.i_rf_ready = 0; #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in(b1); clear_in(b4); clear_in(b8);
    repeat (3) @(posedge clk);
    #3;
    chk_reset(b1, "rst_w1"); chk_reset(b4, "rst_w4"); chk_reset(b8, "rst_w8");
    @(negedge clk) rst_n = 1;
    tick(); #1;
    check("release_ibus", {b1.o_ibus_cyc, b4.o_ibus_cyc, b8.o_ibus_cyc}, 3'b111);

    // W=1 single-stage op
    do_fetch(b1, "w1");
    for (int i = 0; i < 32; i++) begin
      check("w1_run", {b1.o_cnt_en, b1.o_cnt_done, b1.o_ctrl_pc_en, b1.o_rf_rreq, b1.o_rf_wreq, b1.o_cnt},
            {1'b1, (i == 31), 1'b1, 2'b00, 5'(i)});
      tick(); #1;
    end
    check("w1_refetch", {b1.o_ibus_cyc, b1.o_cnt_en, b1.o_cnt}, {1'b1, 1'b0, 5'd0});

    // W=4 taken beq; mdu_op must be ignored with MDU=0
    b4.i_two_stage_op = 1; b4.i_branch_op = 1; b4.i_cond_branch = 1; b4.i_alu_cmp = 1; b4.i_mdu_op = 1;
    do_fetch(b4, "beq");
    for (int i = 0; i < 8; i++) begin
      check("beq_init", {b4.o_init, b4.o_cnt_en, b4.o_ctrl_pc_en, b4.o_rf_rreq, b4.o_rf_wreq,
                         b4.o_mdu_valid, b4.o_ctrl_jump, b4.o_cnt},
            {1'b1, 1'b1, 1'b0, 1'b0, (i == 7), 1'b0, 1'b0, 5'(4 * i)});
      tick(); #1;
    end
    check("beq_rfw", {b4.o_ctrl_jump, b4.o_init, b4.o_cnt_en}, 3'b100);
    do_rfwait(b4, "beq");
    for (int i = 0; i < 8; i++) begin
      check("beq_run", {b4.o_ctrl_jump, b4.o_ctrl_pc_en, b4.o_init, b4.o_rf_rreq, b4.o_rf_wreq,
                        b4.o_cnt_done, b4.o_cnt},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (i == 7), 5'(4 * i)});
      tick(); #1;
    end
    check("beq_fetch", {b4.o_ctrl_jump, b4.o_ibus_cyc}, 2'b01);
    clear_in(b4);

    // W=4 load, stray dbus_ack in FETCH ignored, ack on 5th MEMWAIT cycle
    b4.i_two_stage_op = 1; b4.i_dbus_en = 1; b4.i_dbus_ack = 1; #1;
    check("ack_ignored", {b4.o_rf_wreq, b4.o_dbus_cyc, b4.o_rf_rreq}, 3'b000);
    b4.i_dbus_ack = 0;
    do_fetch(b4, "ld");
    for (int i = 0; i < 8; i++) begin
      check("ld_init", {b4.o_mem_bytecnt, b4.o_rf_wreq, b4.o_rf_rreq, b4.o_dbus_cyc}, {2'(i / 2), 3'b000});
      tick(); #1;
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 4) b4.i_dbus_ack = 1;
      #1;
      check("ld_mem", {b4.o_dbus_cyc, b4.o_rf_wreq, b4.o_cnt_en, b4.o_init}, {1'b1, (k == 4), 2'b00});
      tick();
    end
    b4.i_dbus_ack = 0; #1;
    check("ld_rfw", {b4.o_dbus_cyc, b4.o_rf_wreq}, 2'b00);
    do_rfwait(b4, "ld");
    for (int i = 0; i < 8; i++) begin
      check("ld_run", {b4.o_mem_bytecnt, b4.o_cnt, b4.o_ctrl_pc_en}, {2'(i / 2), 5'(4 * i), 1'b1});
      tick(); #1;
    end
    check("ld_fetch", {b4.o_ibus_cyc, b4.o_dbus_cyc}, 2'b10);
    clear_in(b4);

    // W=4 misaligned jal traps (ALIGN=0)
    b4.i_two_stage_op = 1; b4.i_branch_op = 1; b4.i_ctrl_misalign = 1;
    do_fetch(b4, "jal");
    for (int i = 0; i < 8; i++) begin
      check("jal_init", {b4.o_rf_rreq, b4.o_rf_wreq, b4.o_ctrl_trap, b4.o_init}, {(i == 7), 3'b001});
      tick(); #1;
    end
    check("jal_rfw", {b4.o_ctrl_trap, b4.o_ctrl_jump, b4.o_rf_wreq}, 3'b110);
    do_rfwait(b4, "jal");
    for (int i = 0; i < 8; i++) begin
      check("jal_run", {b4.o_ctrl_trap, b4.o_rf_wreq, b4.o_rf_rreq, b4.o_ctrl_pc_en, b4.o_ctrl_jump}, 5'b10011);
      tick(); #1;
    end
    check("jal_fetch", {b4.o_ctrl_trap, b4.o_ctrl_jump, b4.o_ibus_cyc}, 3'b001);
    clear_in(b4);

    // W=8 misaligned jal with ALIGN=1: no trap
    b8.i_two_stage_op = 1; b8.i_branch_op = 1; b8.i_ctrl_misalign = 1;
    do_fetch(b8, "algn");
    for (int i = 0; i < 4; i++) begin
      check("algn_init", {b8.o_rf_rreq, b8.o_rf_wreq, b8.o_ctrl_trap, b8.o_cnt}, {1'b0, (i == 3), 1'b0, 5'(8 * i)});
      tick(); #1;
    end
    check("algn_rfw", {b8.o_ctrl_trap, b8.o_ctrl_jump}, 2'b01);
    do_rfwait(b8, "algn");
    for (int i = 0; i < 4; i++) begin
      check("algn_run", {b8.o_ctrl_trap, b8.o_ctrl_pc_en, b8.o_ctrl_jump}, 3'b011);
      tick(); #1;
    end
    check("algn_fetch", {b8.o_ibus_cyc, b8.o_ctrl_jump}, 2'b10);
    clear_in(b8);

    // W=8 MDU op, ready on 10th MDUWAIT cycle
    b8.i_two_stage_op = 1; b8.i_mdu_op = 1;
    do_fetch(b8, "mdu");
    for (int i = 0; i < 4; i++) begin
      check("mdu_init", {b8.o_rf_wreq, b8.o_mdu_valid, b8.o_rf_rreq}, 3'b000);
      tick(); #1;
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 9) b8.i_mdu_ready = 1;
      #1;
      check("mdu_wait", {b8.o_mdu_valid, b8.o_rf_wreq, b8.o_cnt_en}, {1'b1, (k == 9), 1'b0});
      tick();
    end
    b8.i_mdu_ready = 0; #1;
    check("mdu_rfw", {b8.o_mdu_valid, b8.o_rf_wreq}, 2'b00);
    do_rfwait(b8, "mdu");
    for (int i = 0; i < 4; i++) begin
      check("mdu_run", {b8.o_cnt_en, b8.o_cnt_done, b8.o_cnt, b8.o_mdu_valid}, {1'b1, (i == 3), 5'(8 * i), 1'b0});
      tick(); #1;
    end
    check("mdu_fetch", {b8.o_cnt_en, b8.o_ibus_cyc}, 2'b01);
    clear_in(b8);

    // Asynchronous reset mid-RUN at cnt=12
    b4.i_two_stage_op = 1; b4.i_branch_op = 1;
    do_fetch(b4, "rst");
    repeat (8) begin tick(); #1; end
    do_rfwait(b4, "rst");
    repeat (3) begin tick(); #1; end
    check("rst_pre", {b4.o_cnt, b4.o_ctrl_jump, b4.o_cnt_en}, {5'd12, 1'b1, 1'b1});
    #1 rst_n = 0;
    #1;
    chk_reset(b4, "rst_async_w4");
    chk_reset(b1, "rst_async_w1");
    clear_in(b4);
    @(posedge clk);
    #3;
    chk_reset(b4, "rst_hold");
    @(negedge clk) rst_n = 1;
    tick(); #1;
    check("rst_release", {b4.o_ibus_cyc, b4.o_cnt_en, b4.o_rf_rreq}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serv_seq.md
SERV_SEQ -- requirements
Module: serv_seq

Interface
REQ-001 SHALL have parameter W, default 1: datapath slice width in bits per cycle; legal values 1, 2, 4, 8; any other value is a elaboration error.
REQ-002 SHALL have parameter WITH_CSR, default 1: 1 enables trap generation; 0 ties o_ctrl_trap and trap_pending to 0.
REQ-003 SHALL have parameter ALIGN, default 0: 1 suppresses jump-misalign traps.
REQ-004 SHALL have parameter MDU, default 0: 1 enables the MDU wait state; 0 ties o_mdu_valid to 0 and ignores i_mdu_ready.
REQ-005 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_ibus_ack  in  1  instruction fetch complete; o_ibus_cyc  out  1  instruction fetch request.
REQ-008 i_dbus_ack  in  1  data access complete; o_dbus_cyc  out  1  data access request.
REQ-009 i_rf_ready  in  1  register file ready; starts a phase.
REQ-010 o_rf_rreq  out  1  RF read request pulse; o_rf_wreq  out  1  RF write request pulse.
REQ-011 i_two_stage_op, i_branch_op, i_cond_branch, i_bne_or_bge, i_dbus_en, i_mdu_op, i_e_op  in  1 each  decoded instruction class.
REQ-012 i_alu_cmp  in  1  compare result, valid in last INIT cycle; i_ctrl_misalign, i_mem_misalign  in  1 each  misalign flags.
REQ-013 i_new_irq  in  1  pending interrupt; i_mdu_ready  in  1  MDU result ready.
REQ-014 o_cnt  out  5  bit index of LSB of current slice; o_cnt_en  out  1  counter running; o_cnt_done  out  1  last slice of phase.
REQ-015 o_init  out  1  phase 1 active; o_ctrl_pc_en  out  1  PC update enable; o_ctrl_jump  out  1  registered take-branch; o_ctrl_trap  out  1  trap in progress.
REQ-016 o_mem_bytecnt  out  2  equals o_cnt[4:3]; o_mdu_valid  out  1  MDU start/hold.

Function
REQ-017 SHALL implement FSM states FETCH, RFWAIT, INIT, MEMWAIT, MDUWAIT, RUN.
REQ-018 FETCH: o_ibus_cyc=1; on i_ibus_ack, o_rf_rreq=1 same cycle, next state RFWAIT, o_ibus_cyc=0 next cycle.
REQ-019 RFWAIT: on i_rf_ready, next state INIT if pending op is two-stage and i_new_irq=0 and phase 1 not done, else RUN; o_cnt_en=1 from next cycle.
REQ-020 Counter: o_cnt resets to 0 at phase start, increments by W each o_cnt_en cycle; o_cnt_done = o_cnt_en & (o_cnt == 32-W); phase lasts exactly 32/W cycles; o_cnt wraps to 0 after done.
REQ-021 take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge)); trap_pending = WITH_CSR & ((take_branch & i_ctrl_misalign & !ALIGN) | (i_dbus_en & i_mem_misalign)).
REQ-022 Last INIT cycle, priority order: trap_pending -> o_rf_rreq=1, trap flag set, next RFWAIT; else i_dbus_en -> MEMWAIT; else MDU & i_mdu_op -> MDUWAIT; else o_rf_wreq=1, next RFWAIT.
REQ-023 Last INIT cycle SHALL register o_ctrl_jump <= take_branch; o_ctrl_jump cleared at RUN o_cnt_done.
REQ-024 MEMWAIT: o_dbus_cyc=1 until i_dbus_ack; on ack o_rf_wreq=1 same cycle, next RFWAIT.
REQ-025 MDUWAIT: o_mdu_valid=1 until i_mdu_ready; on ready o_rf_wreq=1 same cycle, next RFWAIT.
REQ-026 RUN: o_ctrl_pc_en = o_cnt_en & !o_init; on o_cnt_done next state FETCH, o_ibus_cyc=1 next cycle, trap flag cleared.
REQ-027 o_ctrl_trap = WITH_CSR & (i_e_op | i_new_irq | trap flag).
REQ-028 Acks arriving in states other than their waiting state SHALL be ignored.
REQ-029 o_init=1 only in INIT; o_cnt_en=0 in FETCH, RFWAIT, MEMWAIT, MDUWAIT.

Reset
REQ-030 While i_rst_n=0: state FETCH, o_cnt=0, o_cnt_en=0, o_ctrl_jump=0, trap flag=0, o_ibus_cyc=0, all request pulses 0.
REQ-031 First rising edge after i_rst_n=1 SHALL present o_ibus_cyc=1; reset mid-phase SHALL abort immediately with no further pulses.

Verification
REQ-032 W=1, single-stage op: ibus_ack, rf_ready one cycle later -> rreq 1 pulse, exactly 32 o_cnt_en cycles, o_cnt 0..31, o_ibus_cyc=1 next cycle after done.
REQ-033 W=4, two-stage beq with alu_cmp=1 -> INIT 8 cycles, o_cnt 0,4,..,28, wreq in cycle 8, o_ctrl_jump=1 through RUN, cleared after RUN done.
REQ-034 Load with dbus_ack delayed 5 cycles -> o_dbus_cyc high 5 cycles, wreq coincident with ack, o_mem_bytecnt follows o_cnt[4:3].
REQ-035 WITH_CSR=1, ALIGN=0, jal with ctrl_misalign=1 -> rreq in last INIT cycle, o_ctrl_trap=1 through RUN, no wreq; ALIGN=1 -> no trap.
REQ-036 W=8, MDU=1, mdu op with ready after 10 cycles -> o_mdu_valid high 10 cycles, wreq on ready, RUN 4 cycles.
REQ-037 Assert i_rst_n=0 mid-RUN at o_cnt=12 -> all outputs reset values asynchronously, o_ibus_cyc=1 first edge after release.
